mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
- Upstream stage of the 2:1 data-flow mux: arbitrates between two valid/ready input streams (A, B) and generates the registered Select for the downstream 2:1 mux.
- Also forwards the winning data through a one-entry output register.
- Round-robin between single-beat transfers; multi-beat packets (framed by *_last) are locked to one source until the last beat.

Parameters:
- WIDTH, 8, data width of each input and of the output stream.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  stream A beat valid.
- a_data  input  WIDTH  stream A data.
- a_last  input  1  stream A final beat of packet.
- a_ready  output  1  stream A beat accepted this cycle.
- b_valid  input  1  stream B beat valid.
- b_data  input  WIDTH  stream B data.
- b_last  input  1  stream B final beat of packet.
- b_ready  output  1  stream B beat accepted this cycle.
- select  output  1  registered source of the most recently accepted beat (0=A, 1=B); drives the downstream mux Select.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  output beat data.
- out_last  output  1  output beat is last of packet.
- out_ready  input  1  downstream accepts the output beat.

Behaviour:
- Reset (rst_n low, async, any time): state=IDLE, prio=0 (A preferred), select=0, out_valid=0, out_data=0, out_last=0. Any partial packet is dropped; upstream resends it.
- a_ready/b_ready are combinational; 0 while rst_n low.
- can_load = !out_valid || out_ready. This gives a combinational path from out_ready to a_ready/b_ready.
- FSM states: IDLE, LOCK_A, LOCK_B.
- IDLE with can_load:
  - only a_valid: grant A.
  - only b_valid: grant B.
  - both valid: grant A if prio=0, else B.
  - neither valid: no grant, ready=0.
- LOCK_A: a_ready = can_load; b_ready = 0 regardless of b_valid. LOCK_B is symmetric.
- Accept (x_valid && x_ready), on the same edge:
  - out_data <= x_data, out_last <= x_last, out_valid <= 1, select <= source.
  - If x_last=1: next state IDLE and prio <= ~source.
  - If x_last=0: next state LOCK_source.
- No accept and out_ready=1: out_valid <= 0.
- out_valid && !out_ready: out_data, out_last and select hold; no input is accepted.
- Latency: 1 cycle from input accept to out_valid. Throughput is 1 beat/cycle with out_ready held high.
- Locked source deasserts valid mid-packet: remain locked, other source starves until the last beat is accepted.
- a_last/b_last are sampled only on accept; valid=0 beats are ignored.
- Fairness: a source granted a complete packet loses priority to the other source on the next contested IDLE cycle.

Decomposition:
- Package mux2_pkg holds:
  - state encoding constants ST_IDLE=2'b00, ST_LOCK_A=2'b01, ST_LOCK_B=2'b10;
  - source constants SRC_A=1'b0, SRC_B=1'b1;
  - default WIDTH.
- One sub-module, mux2_out_reg: the one-entry output register with load/hold/clear and async reset.
- Arbitration FSM and ready generation stay in mux2_rr_arbiter.

Test Plan:
- Reset: rst_n=0 with a_valid=b_valid=1 -> out_valid=0, out_data=0x00, select=0, a_ready=b_ready=0. Release with out_ready=1 -> first accepted beat is from A.
- Alternation: a_valid=b_valid=1 continuously, all last=1, a_data=0x11, b_data=0x22, out_ready=1 -> out_data sequence 0x11,0x22,0x11,0x22 on consecutive cycles; select 0,1,0,1.
- Packet lock: A sends 0xA0,0xA1,0xA2(last); B holds 0xB0(last) valid throughout -> out 0xA0,0xA1,0xA2,0xB0; b_ready=0 for the first three cycles.
- Backpressure: out_valid=1 with out_data=0x5A, out_ready=0 for 3 cycles -> out_data=0x5A, select stable, a_ready=b_ready=0. Raise out_ready -> next beat loads on the following edge.
- Async reset mid-packet: accept 0xA0 with a_last=0, drop rst_n mid-cycle -> out_valid=0 immediately. After release, only b_valid=1 with 0xB1(last) -> out_data=0xB1, select=1, state IDLE, prio=0.
- Lone requester against priority: prio=0, only b_valid=1 with 0xC3(last) -> B granted next cycle, out_data=0xC3. Then both valid -> A wins.

Source files
------------

// File: rtl/mux2_pkg.sv
// mux2_pkg: shared definitions for the 2:1 round-robin arbiter slice.
//   - state_e   : arbitration FSM encoding (idle / locked to A / locked to B)
//   - SRC_A/B   : source identifiers, also the value driven on select
//   - WIDTH_DEF : default data width
//   - other_src : returns the opposite source (used for priority rotation)
package mux2_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOCK_A = 2'b01,
    ST_LOCK_B = 2'b10
  } state_e;

  function automatic logic other_src(input logic src);
    return ~src;
  endfunction

endpackage

// File: rtl/mux2_out_reg.sv
// mux2_out_reg: one-entry output register (valid/data/last).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (clears all fields)
//   load_i      : capture data_i/last_i and set valid (wins over clear_i)
//   clear_i     : drop valid when nothing is loaded; data/last hold
//   data_i      : beat data to capture
//   last_i      : beat last flag to capture
//   valid_o     : register holds a beat
//   data_o      : held beat data
//   last_o      : held beat last flag
module mux2_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             last_q,  last_d;

  // Next-state selection: load, else clear valid, else hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Register storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin arbiter between two valid/ready streams with
// packet locking, feeding a one-entry output register and producing the
// registered select for the downstream 2:1 mux.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   a_valid/a_data/a_last/a_ready  : stream A (ready is combinational)
//   b_valid/b_data/b_last/b_ready  : stream B (ready is combinational)
//   select                         : source of most recently accepted beat
//   out_valid/out_data/out_last    : output register contents
//   out_ready                      : downstream accepts the output beat
module mux2_rr_arbiter
  import mux2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             select,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
);

  state_e state_q, state_d;
  logic   prio_q,  prio_d;
  logic   select_q, select_d;

  logic             can_load_s;
  logic             a_grant_s, b_grant_s;
  logic             acc_a_s, acc_b_s;
  logic             load_s;
  logic [WIDTH-1:0] load_data_s;
  logic             load_last_s;
  logic             oreg_valid_s;

  // The output slot is free if empty or being drained this cycle; this is
  // the combinational out_ready -> x_ready path.
  assign can_load_s = !oreg_valid_s || out_ready;

  // Grant generation: IDLE arbitrates by priority, LOCK_x serves only x.
  always_comb begin
    a_grant_s = 1'b0;
    b_grant_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!can_load_s) begin
          a_grant_s = 1'b0;
          b_grant_s = 1'b0;
        end else if (a_valid && (!b_valid || (prio_q == SRC_A))) begin
          a_grant_s = 1'b1;
        end else if (b_valid) begin
          b_grant_s = 1'b1;
        end else begin
          a_grant_s = 1'b0;
          b_grant_s = 1'b0;
        end
      end
      // Locked: ready follows can_load even when the owner is idle, so the
      // other source stays starved until the owner's last beat.
      ST_LOCK_A: a_grant_s = can_load_s;
      ST_LOCK_B: b_grant_s = can_load_s;
      default: begin
        a_grant_s = 1'b0;
        b_grant_s = 1'b0;
      end
    endcase
  end

  assign a_ready = a_grant_s && rst_n;
  assign b_ready = b_grant_s && rst_n;

  assign acc_a_s = a_valid && a_grant_s;
  assign acc_b_s = b_valid && b_grant_s;

  // FSM next state, priority rotation and select update on accept.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    select_d = select_q;
    if (acc_a_s) begin
      select_d = SRC_A;
      if (a_last) begin
        state_d = ST_IDLE;
        prio_d  = other_src(SRC_A);
      end else begin
        state_d = ST_LOCK_A;
      end
    end else if (acc_b_s) begin
      select_d = SRC_B;
      if (b_last) begin
        state_d = ST_IDLE;
        prio_d  = other_src(SRC_B);
      end else begin
        state_d = ST_LOCK_B;
      end
    end else begin
      case (state_q)
        ST_IDLE, ST_LOCK_A, ST_LOCK_B: state_d = state_q;
        default:                       state_d = ST_IDLE;
      endcase
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      prio_q   <= SRC_A;
      select_q <= SRC_A;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      select_q <= select_d;
    end
  end

  assign load_s      = acc_a_s || acc_b_s;
  assign load_data_s = acc_b_s ? b_data : a_data;
  assign load_last_s = acc_b_s ? b_last : a_last;

  mux2_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load_s),
    .clear_i (out_ready),
    .data_i  (load_data_s),
    .last_i  (load_last_s),
    .valid_o (oreg_valid_s),
    .data_o  (out_data),
    .last_o  (out_last)
  );

  assign out_valid = oreg_valid_s;
  assign select    = select_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed, table-driven bench for mux2_rr_arbiter. Each vector drives the
// inputs for one cycle, checks the combinational readies before the edge and
// the registered outputs just after it.
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, a_last, a_ready;
  logic [7:0] a_data;
  logic       b_valid, b_last, b_ready;
  logic [7:0] b_data;
  logic       select, out_valid, out_last, out_ready;
  logic [7:0] out_data;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       av;
    logic [7:0] ad;
    logic       al;
    logic       bv;
    logic [7:0] bd;
    logic       bl;
    logic       ordy;
    logic       ear;
    logic       ebr;
    logic       eov;
    logic [7:0] eod;
    logic       eol;
    logic       esel;
    logic       cd;    // compare out_data/out_last (off when the slot is empty)
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  mux2_rr_arbiter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_last    (a_last),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_last    (b_last),
    .b_ready   (b_ready),
    .select    (select),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  // Apply one vector: called just after a rising edge, ends just after the next.
  task automatic run_vec(input vec_t v, input int idx);
    a_valid   = v.av;
    a_data    = v.ad;
    a_last    = v.al;
    b_valid   = v.bv;
    b_data    = v.bd;
    b_last    = v.bl;
    out_ready = v.ordy;
    @(negedge clk);
    chk("a_ready", idx, {7'd0, a_ready}, {7'd0, v.ear});
    chk("b_ready", idx, {7'd0, b_ready}, {7'd0, v.ebr});
    @(posedge clk);
    #1;
    chk("out_valid", idx, {7'd0, out_valid}, {7'd0, v.eov});
    chk("select", idx, {7'd0, select}, {7'd0, v.esel});
    if (v.cd) begin
      chk("out_data", idx, out_data, v.eod);
      chk("out_last", idx, {7'd0, out_last}, {7'd0, v.eol});
    end
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_data = 8'h00; a_last = 1'b0;
    b_valid = 1'b0; b_data = 8'h00; b_last = 1'b0;
  endtask

  initial begin
    //            av   ad     al   bv   bd     bl   or   ar   br   ov   od     ol   sel  cd
    // Alternation, all single-beat.
    vecs[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1};
    // Packet lock: A0,A1,A2(last) while B0 waits.
    vecs[4]  = '{1'b1, 8'hA0, 1'b0, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 8'hA2, 1'b1, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b1};
    // Backpressure: load 5A, stall 3 cycles, then release.
    vecs[8]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 8'h66, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 8'h66, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 8'h66, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 8'h66, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 1'b1};
    // Drain to empty; select keeps last source.
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    // Locked owner drops valid mid-packet: B still starved.
    vecs[14] = '{1'b1, 8'hC0, 1'b0, 1'b1, 8'hD0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hD0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 8'hC1, 1'b1, 1'b1, 8'hD0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC1, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 8'hC2, 1'b1, 1'b1, 8'hD0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hD0, 1'b1, 1'b1, 1'b1};
    vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    // Empty slot loads even with out_ready low; then full slot blocks.
    vecs[19] = '{1'b1, 8'hE5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hE5, 1'b1, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hE5, 1'b1, 1'b0, 1'b1};
    vecs[21] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hF0, 1'b1, 1'b1, 1'b1};

    // Reset with both sources requesting.
    rst_n     = 1'b0;
    out_ready = 1'b1;
    a_valid = 1'b1; a_data = 8'h11; a_last = 1'b1;
    b_valid = 1'b1; b_data = 8'h22; b_last = 1'b1;
    #12;
    chk("rst_out_valid", 0, {7'd0, out_valid}, 8'h00);
    chk("rst_out_data", 0, out_data, 8'h00);
    chk("rst_out_last", 0, {7'd0, out_last}, 8'h00);
    chk("rst_select", 0, {7'd0, select}, 8'h00);
    chk("rst_a_ready", 0, {7'd0, a_ready}, 8'h00);
    chk("rst_b_ready", 0, {7'd0, b_ready}, 8'h00);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], i);
    end

    // Async reset mid-packet: A0 accepted without last, then reset.
    run_vec('{1'b1, 8'hA0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b1}, 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 101, {7'd0, out_valid}, 8'h00);
    chk("mrst_out_data", 101, out_data, 8'h00);
    chk("mrst_select", 101, {7'd0, select}, 8'h00);
    chk("mrst_a_ready", 101, {7'd0, a_ready}, 8'h00);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Lock was dropped: lone B gets through.
    run_vec('{1'b0, 8'h00, 1'b0, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b1}, 102);
    // B finished a packet, so A is preferred on contention.
    run_vec('{1'b1, 8'h33, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1}, 103);
    // Contended again: B now wins, leaving prio at A.
    run_vec('{1'b1, 8'h55, 1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 1'b1}, 104);
    // Lone requester B against prio=A.
    run_vec('{1'b0, 8'h00, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b1}, 105);
    // Both valid afterwards: A wins.
    run_vec('{1'b1, 8'h77, 1'b1, 1'b1, 8'h88, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1}, 106);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
